// File: rtl/pattern_tx_pkg.sv
// Shared constants for the pattern transmitter: FSM state encoding,
// default sync pattern and counter sizing.
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_PAY  = 2'b10,
        ST_GAP  = 2'b11
    } state_t;

    localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1010;
    localparam int         PREAMBLE_BITS    = 4;
    localparam int         CNT_W            = 4;

    // The counter holds "bits remaining after this one", so a phase of n bits loads n-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/pattern_tx_if.sv
// Upstream word handshake into the pattern transmitter.
interface pattern_tx_if #(
    parameter int PAYLOAD_W = 8
);
    logic [PAYLOAD_W-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter: load has priority, shifts toward the MSB,
// msb is a direct register tap so it is glitch-free.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_shifted;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign w_shifted[gi] = 1'b0;
            end else begin : g_bit
                assign w_shifted[gi] = r_sr[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= din;
        end else if (shift) begin
            r_sr <= w_shifted;
        end
    end

    assign msb = r_sr[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// Framed serial transmitter: preamble, MSB-first payload, then a low gap.
// cst and x_out change on the same edge, so the line bit always matches the shown state.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int         PAYLOAD_W  = 8,
    parameter int         GAP_CYCLES = 2,
    parameter logic [3:0] PREAMBLE   = DEFAULT_PREAMBLE
) (
    input  logic         clk,
    input  logic         rst,
    pattern_tx_if.slave  s_if,
    output logic         x_out,
    output logic         busy,
    output logic         frame_done,
    output logic [1:0]   cst
);

    localparam logic [CNT_W-1:0] PRE_LOAD = cnt_load(PREAMBLE_BITS);
    localparam logic [CNT_W-1:0] PAY_LOAD = cnt_load(PAYLOAD_W);
    localparam logic [CNT_W-1:0] GAP_LOAD = cnt_load(GAP_CYCLES);

    state_t           r_cst;
    state_t           w_cst_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             r_x_out;
    logic             w_x_next;
    logic             r_frame_done;
    logic             w_done_next;
    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;

    assign s_if.data_ready = (r_cst == ST_IDLE) && !rst;
    assign busy            = (r_cst != ST_IDLE) && !rst;
    assign w_accept        = s_if.data_valid && s_if.data_ready;
    assign w_cnt_dec       = r_cnt - CNT_W'(1);

    piso_shift #(
        .WIDTH (PAYLOAD_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .din   (s_if.data_in),
        .msb   (w_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cst        <= ST_IDLE;
            r_cnt        <= '0;
            r_x_out      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cst        <= w_cst_next;
            r_cnt        <= w_cnt_next;
            r_x_out      <= w_x_next;
            r_frame_done <= w_done_next;
        end
    end

    // Outputs are computed for the state being entered, so the bit registered
    // here is the one that belongs to the next cycle's state.
    always_comb begin
        w_cst_next  = r_cst;
        w_cnt_next  = r_cnt;
        w_x_next    = 1'b0;
        w_done_next = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_cst)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cst_next = ST_PRE;
                    w_cnt_next = PRE_LOAD;
                    w_x_next   = PREAMBLE[PREAMBLE_BITS-1];
                    w_load     = 1'b1;
                end
            end
            ST_PRE: begin
                if (r_cnt != '0) begin
                    w_cnt_next = w_cnt_dec;
                    w_x_next   = PREAMBLE[w_cnt_dec[1:0]];
                end else begin
                    w_cst_next  = ST_PAY;
                    w_cnt_next  = PAY_LOAD;
                    w_x_next    = w_msb;
                    w_shift     = 1'b1;
                    w_done_next = (PAY_LOAD == '0);
                end
            end
            ST_PAY: begin
                if (r_cnt != '0) begin
                    w_cnt_next  = w_cnt_dec;
                    w_x_next    = w_msb;
                    w_shift     = 1'b1;
                    w_done_next = (w_cnt_dec == '0);
                end else begin
                    w_cst_next = ST_GAP;
                    w_cnt_next = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_next = w_cnt_dec;
                end else begin
                    w_cst_next = ST_IDLE;
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_cst_next = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    assign x_out      = r_x_out;
    assign frame_done = r_frame_done;
    assign cst        = r_cst;

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter PAYLOAD_W, default 8: payload bits per frame, legal range 1..16.
REQ-002 Parameter GAP_CYCLES, default 2: idle-low bit times after each payload, legal range 1..15.
REQ-003 Parameter PREAMBLE, default 4'b1010: sync pattern sent MSB first ahead of every payload.
REQ-004 clk  input  1  rising-edge clock; every register is clocked by clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  PAYLOAD_W  payload word, sampled on the accept cycle.
REQ-007 data_valid  input  1  upstream holds a word.
REQ-008 data_ready  output  1  block can accept a word this cycle.
REQ-009 x_out  output  1  registered serial line, one bit per clk.
REQ-010 busy  output  1  a frame is in progress.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last payload bit.
REQ-012 cst  output  2  current FSM state, for debug.

Function
REQ-013 The FSM SHALL have four states: IDLE=2'b00, PRE=2'b01, PAY=2'b10 and GAP=2'b11.
REQ-014 data_ready SHALL be 1 only when cst==IDLE and rst==0.
REQ-015 Accept SHALL occur on data_valid&&data_ready; data_in SHALL be latched into a PAYLOAD_W shift register on that edge.
REQ-016 Frame timing SHALL be as follows, with accept in cycle N:
- Cycles N+1..N+4: x_out = PREAMBLE[3..0] (1,0,1,0 by default).
- Cycles N+5..N+4+PAYLOAD_W: x_out = payload, MSB first.
- Next GAP_CYCLES cycles: x_out=0.
- Following cycle: cst==IDLE.
REQ-017 With default parameters, a frame SHALL occupy 14 cycles, and the next accept SHALL be possible at N+15 at the earliest.
REQ-018 State transitions SHALL be:
- IDLE->PRE on accept.
- PRE->PAY after 4 bits.
- PAY->GAP after PAYLOAD_W bits.
- GAP->IDLE after GAP_CYCLES.
- No other transitions.
REQ-019 A single 4-bit down-counter SHALL time PRE, PAY and GAP, reloaded on each state entry.
REQ-020 In IDLE, x_out SHALL be 0 (idle line low).
REQ-021 busy SHALL be 1 whenever cst!=IDLE.
REQ-022 frame_done SHALL be 1 exactly during the cycle that carries payload bit 0, once per frame.
REQ-023 data_valid and data_in SHALL be ignored outside IDLE; a word offered while busy SHALL stay pending and be accepted in the first IDLE cycle.
REQ-024 Payload content SHALL NOT be inspected; a payload that itself contains 1010 SHALL be sent unchanged.
REQ-025 Every output SHALL be glitch-free registered, except data_ready and busy, which SHALL decode cst only.

Reset
REQ-026 On a clk edge with rst=1, the block SHALL set cst=IDLE, x_out=0, frame_done=0, counter=0 and shift register=0.
REQ-027 While rst=1, data_ready SHALL be 0 and busy SHALL be 0.
REQ-028 Reset mid-frame SHALL abort the frame, drive x_out=0 from the next cycle, and not pulse frame_done.
REQ-029 If rst=1 coincides with data_valid=1, the word SHALL NOT be accepted.

Structure
REQ-030 Package pattern_tx_pkg SHALL hold the state encoding constants and the default PREAMBLE value.
REQ-031 The payload shifter SHALL be a sub-module piso_shift, parameterized by width, with load, shift and msb ports.
REQ-032 The FSM, counter and output register SHALL reside in pattern_tx.

Verification
REQ-033 Single frame: after reset, data_in=8'hA5 with valid for 1 cycle -> x_out from N+1 reads 1010_10100101_00; frame_done at N+12; ready again at N+15.
REQ-034 Back-to-back: valid held high with 8'h3C then 8'hFF -> second preamble starts at N+16; no valid bit is lost; ready is low N+1..N+14.
REQ-035 Reset mid-payload: rst for 1 cycle at N+7 -> x_out=0 from N+8, cst=IDLE, no frame_done, ready=1 after rst falls.
REQ-036 Busy ignore: data_in changed to 8'h00 at N+3 while busy -> transmitted payload stays 8'hA5.
REQ-037 Loopback: x_out fed to the team's Mealy 1010 detector -> one detect per preamble for payload 8'h00; extra detects for payload 8'h0A (in-payload pattern) without affecting the TX.
REQ-038 Parameter corner: PAYLOAD_W=1 and GAP_CYCLES=1 -> frame = 1010,d,0 (6 cycles); frame_done aligned with bit d.
